// File: rtl/serial_paralelo_align_if.sv
// serial_paralelo_align_if: serial input and aligned parallel output bundle of the receiver.
// The receiver sits on the slave side; the serial source and the consumer sit on the master side.
interface serial_paralelo_align_if #(
    parameter int WIDTH = 8
) ();
    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             active;
    logic             word_strobe;
    modport master (output data_in, input data_out, valid_out, active, word_strobe);
    modport slave (input data_in, output data_out, valid_out, active, word_strobe);
endinterface

// File: rtl/serial_paralelo_align.sv
// serial_paralelo_align: serial-to-parallel receiver with comma word alignment and lock/loss tracking.
// Optional SP_COMMA_FILTER_EN: comma words seen while locked update data_out without pulsing valid_out.
module serial_paralelo_align #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3
) (
    input logic                    clk_32f,
    input logic                    reset_L,
    serial_paralelo_align_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int KW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] sr_q, sr_d, data_q;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [KW-1:0]    comma_cnt_q, comma_cnt_d;
    logic [MW-1:0]    miss_cnt_q;
    logic             valid_q, active_q, hit, boundary, emit_ok;
    always_comb begin
        sr_d        = {sr_q[WIDTH-2:0], bus.data_in};
        bit_cnt_d   = (bit_cnt_q == CW'(WIDTH - 1)) ? '0 : bit_cnt_q + CW'(1);
        comma_cnt_d = (comma_cnt_q == KW'(LOCK_COUNT)) ? comma_cnt_q : comma_cnt_q + KW'(1);
    end
    assign hit      = sr_q == COMMA;
    assign boundary = bit_cnt_q == '0;
`ifdef SP_COMMA_FILTER_EN
    assign emit_ok = !hit;
`else
    assign emit_ok = 1'b1;
`endif
    // A boundary comma clears miss_cnt, so loss is only ever detected off-boundary.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            miss_cnt_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= 1'b0;
            case (state_q)
                HUNT: if (hit) begin
                    bit_cnt_q   <= CW'(1);
                    comma_cnt_q <= KW'(1);
                    state_q     <= SYNC;
                end
                SYNC: if (boundary) begin
                    if (!hit) begin
                        state_q     <= HUNT;
                        comma_cnt_q <= '0;
                    end else begin
                        comma_cnt_q <= comma_cnt_d;
                        if (comma_cnt_q == KW'(LOCK_COUNT - 1)) begin
                            state_q    <= LOCKED;
                            active_q   <= 1'b1;
                            miss_cnt_q <= '0;
                        end
                    end
                end
                LOCKED: if (boundary) begin
                    data_q  <= sr_q;
                    valid_q <= emit_ok;
                    if (hit) miss_cnt_q <= '0;
                end else if (hit) begin
                    if (miss_cnt_q == MW'(LOSS_COUNT - 1)) begin
                        state_q     <= HUNT;
                        active_q    <= 1'b0;
                        comma_cnt_q <= '0;
                        miss_cnt_q  <= '0;
                    end else begin
                        miss_cnt_q <= miss_cnt_q + MW'(1);
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    active_q <= 1'b0;
                end
            endcase
        end
    end
    assign bus.data_out    = data_q;
    assign bus.valid_out   = valid_q;
    assign bus.active      = active_q;
    assign bus.word_strobe = boundary && state_q != HUNT;
endmodule

// File: tb/tb_serial_paralelo_align.sv
// tb_serial_paralelo_align: directed bench for lock, payload, filter, loss, abort and async reset.
// Expected comma-word behaviour follows SP_COMMA_FILTER_EN when it is defined for the build.
module tb_serial_paralelo_align;
`ifdef SP_COMMA_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif
    logic clk_32f = 1'b0;
    logic reset_L;
    int   checks = 0;
    int   errors = 0;
    int   npulse = 0;
    int   p0;
    serial_paralelo_align_if #(.WIDTH(8)) bus ();
    serial_paralelo_align #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
        .clk_32f(clk_32f),
        .reset_L(reset_L),
        .bus    (bus)
    );
    always #5 clk_32f = ~clk_32f;
    always @(negedge clk_32f) if (bus.valid_out === 1'b1) npulse++;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic b);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask
    task automatic send_n(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) step(b[i]);
    endtask
    task automatic send_byte(input logic [7:0] b);
        send_n(b, 7, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end
    initial begin
        reset_L     = 1'b1;
        bus.data_in = 1'b0;
        #1 reset_L = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = i[0];
            @(posedge clk_32f);
            #1;
        end
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_valid", 32'(bus.valid_out), 0);
        chk("rst_active", 32'(bus.active), 0);
        chk("rst_strobe", 32'(bus.word_strobe), 0);
        reset_L = 1'b1;
        step(1'b0);
        chk("post_rst_active", 32'(bus.active), 0);
        chk("post_rst_strobe", 32'(bus.word_strobe), 0);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        chk("sync_boundary_strobe", 32'(bus.word_strobe), 1);
        chk("not_yet_active", 32'(bus.active), 0);
        send_n(8'h5A, 7, 7);
        chk("lock_active", 32'(bus.active), 1);
        chk("lock_no_emit", 32'(bus.valid_out), 0);
        send_n(8'h5A, 6, 0);
        chk("5a_in_sr_valid", 32'(bus.valid_out), 0);
        chk("5a_strobe", 32'(bus.word_strobe), 1);
        chk("no_pulse_before_lock", 32'(npulse), 0);
        send_n(8'hC3, 7, 7);
        chk("5a_valid", 32'(bus.valid_out), 1);
        chk("5a_data", 32'(bus.data_out), 'h5A);
        send_n(8'hC3, 6, 6);
        chk("5a_one_cycle", 32'(bus.valid_out), 0);
        chk("5a_hold", 32'(bus.data_out), 'h5A);
        send_n(8'hC3, 5, 0);
        send_n(8'hBC, 7, 7);
        chk("c3_valid", 32'(bus.valid_out), 1);
        chk("c3_data", 32'(bus.data_out), 'hC3);
        send_n(8'hBC, 6, 0);
        p0 = npulse;
        chk("two_pulses", 32'(p0), 2);
        send_n(8'h11, 7, 7);
        chk("comma_word_data", 32'(bus.data_out), 'hBC);
        chk("comma_word_valid", 32'(bus.valid_out), FILT ? 0 : 1);
        send_n(8'h11, 6, 0);
        send_byte(8'hBC);
        send_byte(8'h22);
        send_n(8'h00, 7, 7);
        chk("22_valid", 32'(bus.valid_out), 1);
        chk("22_data", 32'(bus.data_out), 'h22);
        send_n(8'h00, 6, 6);
        chk("filter_pulse_count", 32'(npulse - p0), FILT ? 2 : 4);
        send_n(8'h00, 5, 0);
        send_byte(8'h5E);
        send_byte(8'h00);
        send_byte(8'h5E);
        send_byte(8'h00);
        send_byte(8'hBC);
        send_byte(8'h5E);
        step(1'b0);
        step(1'b0);
        chk("lock_held_by_aligned_bc", 32'(bus.active), 1);
        send_n(8'h00, 5, 0);
        send_byte(8'h5E);
        send_byte(8'h00);
        send_byte(8'h5E);
        step(1'b0);
        chk("pre_loss_active", 32'(bus.active), 1);
        step(1'b0);
        chk("loss_active", 32'(bus.active), 0);
        chk("loss_strobe", 32'(bus.word_strobe), 0);
        send_n(8'h00, 5, 0);
        send_byte(8'h00);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h00);
        chk("abort_sync_strobe", 32'(bus.word_strobe), 1);
        send_byte(8'hBC);
        chk("abort_back_to_hunt", 32'(bus.word_strobe), 0);
        chk("abort_active", 32'(bus.active), 0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("three_fresh_not_locked", 32'(bus.active), 0);
        send_n(8'h5A, 7, 7);
        chk("relock_active", 32'(bus.active), 1);
        send_n(8'h5A, 6, 0);
        send_n(8'h3C, 7, 7);
        chk("relock_5a_valid", 32'(bus.valid_out), 1);
        chk("relock_5a_data", 32'(bus.data_out), 'h5A);
        #2 reset_L = 1'b0;
        #1;
        chk("async_rst_active", 32'(bus.active), 0);
        chk("async_rst_valid", 32'(bus.valid_out), 0);
        chk("async_rst_data", 32'(bus.data_out), 0);
        #10 reset_L = 1'b1;
        step(1'b1);
        chk("after_rst_active", 32'(bus.active), 0);
        chk("after_rst_strobe", 32'(bus.word_strobe), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
